sync_fifo: RTL and testbench

Single-clock, parametrised FIFO; next generation of the team's dual-clock FIFO, for buffering inside one clock domain.
Uses all 2^ADDRESS_WIDTH entries (pointers carry an extra wrap bit), exposes occupancy count, programmable almost-full/almost-empty flags, synchronous flush and sticky overflow/underflow error flags.
Read side is first-word-fall-through: head word is always presented combinationally on read_data.

---
 rtl/sync_fifo_pkg.sv | 14 +
 rtl/sync_fifo_if.sv | 37 +++
 rtl/sync_fifo_pointer.sv | 23 ++
 rtl/sync_fifo_ram.sv | 27 ++
 rtl/sync_fifo.sv | 112 +++++++++++
 tb/tb_sync_fifo.sv | 201 ++++++++++++++++++++
 6 files changed

// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared sizing helpers for the single-clock FIFO
package sync_fifo_pkg;

    // Number of storage entries for a given address width
    function automatic int fifo_depth(input int address_width);
        return 1 << address_width;
    endfunction

    // Pointers carry one extra wrap bit above the memory index
    function automatic int pointer_width(input int address_width);
        return address_width + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// rtl/sync_fifo_if.sv - push/pop/status bundle between a FIFO and its user
interface sync_fifo_if
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 4
) ();

    localparam int PTR_WIDTH = pointer_width(ADDRESS_WIDTH);

    logic                  flush;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  write_increment;
    logic                  full;
    logic                  almost_full;
    logic                  read_increment;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  empty;
    logic                  almost_empty;
    logic [PTR_WIDTH-1:0]  count;
    logic                  clear_errors;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output flush, write_data, write_increment, read_increment, clear_errors,
        input  full, almost_full, read_data, empty, almost_empty, count,
               overflow, underflow
    );

    modport slave (
        input  flush, write_data, write_increment, read_increment, clear_errors,
        output full, almost_full, read_data, empty, almost_empty, count,
               overflow, underflow
    );

endinterface

// File: rtl/sync_fifo_pointer.sv
// rtl/sync_fifo_pointer.sv - wrap-bit pointer counter with enable and sync clear
module sync_fifo_pointer #(
    parameter int WIDTH = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             increment,
    output logic [WIDTH-1:0] value
);

    // Roll over naturally at 2^WIDTH; clear wins over increment
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (increment) begin
            value <= value + 1'b1;
        end
    end

endmodule

// File: rtl/sync_fifo_ram.sv
// rtl/sync_fifo_ram.sv - dual-port RAM, clocked write and combinational read
module sync_fifo_ram #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 4
) (
    input  logic                     clock,
    input  logic                     write_enable,
    input  logic [ADDRESS_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0]    write_data,
    input  logic [ADDRESS_WIDTH-1:0] read_address,
    output logic [DATA_WIDTH-1:0]    read_data
);

    localparam int DEPTH = 1 << ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0] memory [DEPTH];

    // Storage is never reset so it maps onto plain RAM cells
    always_ff @(posedge clock) begin
        if (write_enable) begin
            memory[write_address] <= write_data;
        end
    end

    assign read_data = memory[read_address];

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock first-word-fall-through FIFO with status and sticky errors
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH         = 8,
    parameter int ADDRESS_WIDTH      = 4,
    parameter int ALMOST_FULL_LEVEL  = fifo_depth(ADDRESS_WIDTH) - 2,
    parameter int ALMOST_EMPTY_LEVEL = 2
) (
    input  logic        clock,
    input  logic        reset,
    sync_fifo_if.slave  bus
);

    localparam int DEPTH     = fifo_depth(ADDRESS_WIDTH);
    localparam int PTR_WIDTH = pointer_width(ADDRESS_WIDTH);

    localparam logic [PTR_WIDTH-1:0] AF_LEVEL = PTR_WIDTH'(ALMOST_FULL_LEVEL);
    localparam logic [PTR_WIDTH-1:0] AE_LEVEL = PTR_WIDTH'(ALMOST_EMPTY_LEVEL);

    generate
        if (!(ALMOST_EMPTY_LEVEL > 0 &&
              ALMOST_EMPTY_LEVEL < ALMOST_FULL_LEVEL &&
              ALMOST_FULL_LEVEL < DEPTH + 1)) begin : g_bad_levels
            $error("sync_fifo: need 0 < ALMOST_EMPTY_LEVEL < ALMOST_FULL_LEVEL <= DEPTH");
        end
    endgenerate

    logic [PTR_WIDTH-1:0] write_pointer;
    logic [PTR_WIDTH-1:0] read_pointer;
    logic                 write_accept;
    logic                 read_accept;
    logic                 overflow_set;
    logic                 underflow_set;
    logic                 is_full;
    logic                 is_empty;
    logic [PTR_WIDTH-1:0] occupancy;
    logic                 overflow_q;
    logic                 underflow_q;

    // Status comes from registered pointers only, never from this cycle's requests
    always_comb begin
        occupancy = write_pointer - read_pointer;
        is_empty  = (write_pointer == read_pointer);
        is_full   = (write_pointer[ADDRESS_WIDTH-1:0] == read_pointer[ADDRESS_WIDTH-1:0]) &&
                    (write_pointer[ADDRESS_WIDTH] != read_pointer[ADDRESS_WIDTH]);
    end

    // Flush overrides both sides and also suppresses error reporting
    always_comb begin
        write_accept  = bus.write_increment && !is_full  && !bus.flush;
        read_accept   = bus.read_increment  && !is_empty && !bus.flush;
        overflow_set  = bus.write_increment &&  is_full  && !bus.flush;
        underflow_set = bus.read_increment  &&  is_empty && !bus.flush;
    end

    sync_fifo_pointer #(.WIDTH(PTR_WIDTH)) u_write_pointer (
        .clock     (clock),
        .reset     (reset),
        .clear     (bus.flush),
        .increment (write_accept),
        .value     (write_pointer)
    );

    sync_fifo_pointer #(.WIDTH(PTR_WIDTH)) u_read_pointer (
        .clock     (clock),
        .reset     (reset),
        .clear     (bus.flush),
        .increment (read_accept),
        .value     (read_pointer)
    );

    sync_fifo_ram #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_ram (
        .clock         (clock),
        .write_enable  (write_accept),
        .write_address (write_pointer[ADDRESS_WIDTH-1:0]),
        .write_data    (bus.write_data),
        .read_address  (read_pointer[ADDRESS_WIDTH-1:0]),
        .read_data     (bus.read_data)
    );

    // Sticky error flags; a new error in the clearing cycle keeps the flag set
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (overflow_set) begin
                overflow_q <= 1'b1;
            end else if (bus.clear_errors) begin
                overflow_q <= 1'b0;
            end
            if (underflow_set) begin
                underflow_q <= 1'b1;
            end else if (bus.clear_errors) begin
                underflow_q <= 1'b0;
            end
        end
    end

    assign bus.count        = occupancy;
    assign bus.empty        = is_empty;
    assign bus.full         = is_full;
    assign bus.almost_full  = (occupancy >= AF_LEVEL);
    assign bus.almost_empty = (occupancy <= AE_LEVEL);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - directed self-checking bench for sync_fifo
module tb_sync_fifo;

    localparam int DW = 4;
    localparam int AW = 3;

    logic clock;
    logic reset;
    int   n_compared;
    int   n_mismatched;

    sync_fifo_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

    sync_fifo #(
        .DATA_WIDTH         (DW),
        .ADDRESS_WIDTH      (AW),
        .ALMOST_FULL_LEVEL  (6),
        .ALMOST_EMPTY_LEVEL (2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        n_compared++; if (bus.empty !== 1'b1) begin n_mismatched++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
        n_compared++; if (bus.full !== 1'b0) begin n_mismatched++; $display("FAIL reset_full: got %b want 0", bus.full); end
        n_compared++; if (bus.count !== 4'd0) begin n_mismatched++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        n_compared++; if (bus.almost_empty !== 1'b1) begin n_mismatched++; $display("FAIL reset_almost_empty: got %b want 1", bus.almost_empty); end
        n_compared++; if (bus.almost_full !== 1'b0) begin n_mismatched++; $display("FAIL reset_almost_full: got %b want 0", bus.almost_full); end
        n_compared++; if ({bus.overflow, bus.underflow} !== 2'b00) begin n_mismatched++; $display("FAIL reset_errors: got %b want 00", {bus.overflow, bus.underflow}); end
    endtask

    task automatic test_fill();
        bus.write_increment = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            bus.write_data = 4'(i);
            tick();
            n_compared++; if (bus.count !== 4'(i)) begin n_mismatched++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, bus.count, i); end
            n_compared++; if (bus.almost_empty !== (i <= 2)) begin n_mismatched++; $display("FAIL fill_almost_empty[%0d]: got %b want %b", i, bus.almost_empty, (i <= 2)); end
            n_compared++; if (bus.almost_full !== (i >= 6)) begin n_mismatched++; $display("FAIL fill_almost_full[%0d]: got %b want %b", i, bus.almost_full, (i >= 6)); end
            n_compared++; if (bus.full !== (i == 8)) begin n_mismatched++; $display("FAIL fill_full[%0d]: got %b want %b", i, bus.full, (i == 8)); end
            n_compared++; if (bus.read_data !== 4'h1) begin n_mismatched++; $display("FAIL fill_head[%0d]: got %h want 1", i, bus.read_data); end
        end
        bus.write_data = 4'h9;
        tick();
        bus.write_increment = 1'b0;
        n_compared++; if (bus.overflow !== 1'b1) begin n_mismatched++; $display("FAIL overflow_set: got %b want 1", bus.overflow); end
        n_compared++; if (bus.count !== 4'd8) begin n_mismatched++; $display("FAIL overflow_count: got %0d want 8", bus.count); end
        n_compared++; if (bus.underflow !== 1'b0) begin n_mismatched++; $display("FAIL overflow_underflow: got %b want 0", bus.underflow); end
    endtask

    task automatic test_drain();
        bus.read_increment = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            n_compared++; if (bus.read_data !== 4'(i)) begin n_mismatched++; $display("FAIL drain_data[%0d]: got %h want %h", i, bus.read_data, 4'(i)); end
            tick();
            n_compared++; if (bus.count !== 4'(8 - i)) begin n_mismatched++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, bus.count, 8 - i); end
        end
        n_compared++; if (bus.empty !== 1'b1) begin n_mismatched++; $display("FAIL drain_empty: got %b want 1", bus.empty); end
        tick();
        bus.read_increment = 1'b0;
        n_compared++; if (bus.underflow !== 1'b1) begin n_mismatched++; $display("FAIL underflow_set: got %b want 1", bus.underflow); end
        n_compared++; if (bus.count !== 4'd0) begin n_mismatched++; $display("FAIL underflow_count: got %0d want 0", bus.count); end
        n_compared++; if (bus.overflow !== 1'b1) begin n_mismatched++; $display("FAIL overflow_sticky: got %b want 1", bus.overflow); end
    endtask

    task automatic test_clear_errors();
        bus.clear_errors = 1'b1;
        tick();
        bus.clear_errors = 1'b0;
        n_compared++; if ({bus.overflow, bus.underflow} !== 2'b00) begin n_mismatched++; $display("FAIL clear_errors: got %b want 00", {bus.overflow, bus.underflow}); end
    endtask

    task automatic test_write_read_empty();
        bus.write_data      = 4'hA;
        bus.write_increment = 1'b1;
        bus.read_increment  = 1'b1;
        tick();
        bus.write_increment = 1'b0;
        bus.read_increment  = 1'b0;
        n_compared++; if (bus.underflow !== 1'b1) begin n_mismatched++; $display("FAIL wr_empty_underflow: got %b want 1", bus.underflow); end
        n_compared++; if (bus.read_data !== 4'hA) begin n_mismatched++; $display("FAIL wr_empty_data: got %h want a", bus.read_data); end
        n_compared++; if (bus.count !== 4'd1) begin n_mismatched++; $display("FAIL wr_empty_count: got %0d want 1", bus.count); end
        n_compared++; if (bus.overflow !== 1'b0) begin n_mismatched++; $display("FAIL wr_empty_overflow: got %b want 0", bus.overflow); end
        bus.read_increment = 1'b1;
        tick();
        bus.read_increment = 1'b0;
        n_compared++; if (bus.empty !== 1'b1) begin n_mismatched++; $display("FAIL wr_empty_drained: got %b want 1", bus.empty); end
    endtask

    task automatic test_back_to_back();
        bus.write_increment = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.write_data = 4'(i);
            tick();
        end
        bus.read_increment = 1'b1;
        for (int k = 0; k < 20; k++) begin
            bus.write_data = 4'(5 + k);
            n_compared++; if (bus.read_data !== 4'(1 + k)) begin n_mismatched++; $display("FAIL b2b_data[%0d]: got %h want %h", k, bus.read_data, 4'(1 + k)); end
            tick();
            n_compared++; if (bus.count !== 4'd4) begin n_mismatched++; $display("FAIL b2b_count[%0d]: got %0d want 4", k, bus.count); end
        end
        bus.write_increment = 1'b0;
        bus.read_increment  = 1'b0;
        n_compared++; if (bus.read_data !== 4'h5) begin n_mismatched++; $display("FAIL b2b_head_after: got %h want 5", bus.read_data); end
    endtask

    task automatic test_flush();
        bus.write_data      = 4'h9;
        bus.write_increment = 1'b1;
        tick();
        n_compared++; if (bus.count !== 4'd5) begin n_mismatched++; $display("FAIL flush_pre_count: got %0d want 5", bus.count); end
        bus.flush      = 1'b1;
        bus.write_data = 4'hF;
        tick();
        bus.flush           = 1'b0;
        bus.write_increment = 1'b0;
        n_compared++; if (bus.count !== 4'd0) begin n_mismatched++; $display("FAIL flush_count: got %0d want 0", bus.count); end
        n_compared++; if (bus.empty !== 1'b1) begin n_mismatched++; $display("FAIL flush_empty: got %b want 1", bus.empty); end
        n_compared++; if ({bus.overflow, bus.underflow} !== 2'b01) begin n_mismatched++; $display("FAIL flush_errors_kept: got %b want 01", {bus.overflow, bus.underflow}); end
        bus.clear_errors = 1'b1;
        tick();
        bus.clear_errors = 1'b0;
        n_compared++; if ({bus.overflow, bus.underflow} !== 2'b00) begin n_mismatched++; $display("FAIL flush_clear: got %b want 00", {bus.overflow, bus.underflow}); end
        bus.flush          = 1'b1;
        bus.read_increment = 1'b1;
        tick();
        bus.flush          = 1'b0;
        bus.read_increment = 1'b0;
        n_compared++; if (bus.underflow !== 1'b0) begin n_mismatched++; $display("FAIL flush_no_underflow: got %b want 0", bus.underflow); end
        bus.clear_errors   = 1'b1;
        bus.read_increment = 1'b1;
        tick();
        bus.clear_errors   = 1'b0;
        bus.read_increment = 1'b0;
        n_compared++; if (bus.underflow !== 1'b1) begin n_mismatched++; $display("FAIL set_beats_clear: got %b want 1", bus.underflow); end
    endtask

    task automatic test_async_reset();
        bus.write_increment = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            bus.write_data = 4'(i);
            tick();
        end
        bus.write_increment = 1'b0;
        n_compared++; if (bus.count !== 4'd3) begin n_mismatched++; $display("FAIL areset_pre_count: got %0d want 3", bus.count); end
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        n_compared++; if (bus.count !== 4'd0) begin n_mismatched++; $display("FAIL areset_count: got %0d want 0", bus.count); end
        n_compared++; if (bus.empty !== 1'b1) begin n_mismatched++; $display("FAIL areset_empty: got %b want 1", bus.empty); end
        n_compared++; if ({bus.overflow, bus.underflow} !== 2'b00) begin n_mismatched++; $display("FAIL areset_errors: got %b want 00", {bus.overflow, bus.underflow}); end
        #1;
        reset = 1'b0;
        tick();
        bus.write_data      = 4'h5;
        bus.write_increment = 1'b1;
        tick();
        bus.write_increment = 1'b0;
        n_compared++; if (bus.read_data !== 4'h5) begin n_mismatched++; $display("FAIL areset_after_data: got %h want 5", bus.read_data); end
        n_compared++; if (bus.count !== 4'd1) begin n_mismatched++; $display("FAIL areset_after_count: got %0d want 1", bus.count); end
    endtask

    initial begin
        n_compared          = 0;
        n_mismatched        = 0;
        reset               = 1'b1;
        bus.flush           = 1'b0;
        bus.write_data      = '0;
        bus.write_increment = 1'b0;
        bus.read_increment  = 1'b0;
        bus.clear_errors    = 1'b0;
        test_reset();
        test_fill();
        test_drain();
        test_clear_errors();
        test_write_read_empty();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
